// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and the rest of the system.
// The master side is the surrounding system: it supplies the start and
// score events and the per-game display codes and victory flags.
// The slave side is the sequencer, which drives the enables, counters,
// display bus and status flags.
interface game_sequencer_if #(
    parameter int NUM_GAMES = 3
);
    logic                      start;
    logic                      score_pulse;
    logic [20*NUM_GAMES-1:0]   game_bits;
    logic [NUM_GAMES-1:0]      victory;
    logic [NUM_GAMES-1:0]      game_en;
    logic [2:0]                game_idx;
    logic [2:0]                game_counter;
    logic [19:0]               bits;
    logic [5:0]                seconds_left;
    logic                      done;
    logic                      fail;

    modport master (
        output start, score_pulse, game_bits, victory,
        input  game_en, game_idx, game_counter, bits, seconds_left, done, fail
    );

    modport slave (
        input  start, score_pulse, game_bits, victory,
        output game_en, game_idx, game_counter, bits, seconds_left, done, fail
    );
endinterface

// File: rtl/game_sequencer.sv
// Steps the player through NUM_GAMES mini-games in a fixed order. One game is
// active at a time; its display codes are routed to the shared display bus.
// Each game gets a countdown, and the winning game's display is held for a
// short while before the sequencer advances.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, display shows dashes, waiting for start
// LOAD  | one cycle: enable the game at game_idx, reload its countdown
// PLAY  | game running; score, victory and countdown are live
// WIN   | current game won; its display is held for WIN_HOLD seconds
// LOSE  | countdown expired; sticky until start
// DONE  | every game won; shows total elapsed seconds; sticky until start
module game_sequencer #(
    parameter int NUM_GAMES  = 3,
    parameter int TICK_DIV   = 50_000_000,
    parameter int TIME_LIMIT = 30,
    parameter int WIN_HOLD   = 2
) (
    input logic             clk,
    input logic             reset_n,
    game_sequencer_if.slave bus
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [4:0]  DASH  = 5'b10000;
    localparam logic [4:0]  BLANK = 5'b11111;
    localparam logic [19:0] DASH4 = {DASH, DASH, DASH, DASH};
    localparam logic [19:0] LOSE_BITS = {BLANK, DASH, DASH, BLANK};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_WIN,
        S_LOSE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             hold_cnt;
    logic [3:0]             el_ones;
    logic [3:0]             el_tens;
    logic [NUM_GAMES-1:0]   game_en_r;
    logic [2:0]             game_idx_r;
    logic [2:0]             game_counter_r;
    logic [19:0]            bits_r;
    logic [5:0]             seconds_left_r;
    logic                   done_r;
    logic                   fail_r;

    logic                   tick;
    logic [19:0]            cur_bits;
    logic                   cur_victory;

    // The one-second divider only advances while a game is on screen.
    assign tick = ((state == S_PLAY) || (state == S_WIN)) && (div_cnt == '0);

    // Select the active game's display slice and victory flag.
    always_comb begin
        cur_bits    = DASH4;
        cur_victory = 1'b0;
        for (int i = 0; i < NUM_GAMES; i++) begin
            if (game_idx_r == 3'(i)) begin
                cur_bits    = bus.game_bits[20*i +: 20];
                cur_victory = bus.victory[i];
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            div_cnt        <= DIV_LOAD;
            hold_cnt       <= '0;
            el_ones        <= '0;
            el_tens        <= '0;
            game_en_r      <= '0;
            game_idx_r     <= '0;
            game_counter_r <= '0;
            bits_r         <= DASH4;
            seconds_left_r <= '0;
            done_r         <= 1'b0;
            fail_r         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_LOSE, S_DONE: begin
                    if (bus.start) begin
                        state          <= S_LOAD;
                        game_idx_r     <= '0;
                        game_en_r      <= NUM_GAMES'(1);
                        game_counter_r <= '0;
                        seconds_left_r <= 6'(TIME_LIMIT);
                        div_cnt        <= DIV_LOAD;
                        el_ones        <= '0;
                        el_tens        <= '0;
                        done_r         <= 1'b0;
                        fail_r         <= 1'b0;
                    end
                end

                S_LOAD: begin
                    state   <= S_PLAY;
                    div_cnt <= DIV_LOAD;
                    bits_r  <= cur_bits;
                end

                S_PLAY: begin
                    bits_r <= cur_bits;
                    if (bus.score_pulse && (game_counter_r != 3'd7))
                        game_counter_r <= game_counter_r + 3'd1;
                    if (tick) begin
                        div_cnt <= DIV_LOAD;
                        if (seconds_left_r != '0)
                            seconds_left_r <= seconds_left_r - 6'd1;
                        if (!((el_tens == 4'd9) && (el_ones == 4'd9))) begin
                            if (el_ones == 4'd9) begin
                                el_ones <= '0;
                                el_tens <= el_tens + 4'd1;
                            end else begin
                                el_ones <= el_ones + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                    // Victory takes priority over a simultaneous expiring tick.
                    if (cur_victory) begin
                        state    <= S_WIN;
                        div_cnt  <= DIV_LOAD;
                        hold_cnt <= 6'(WIN_HOLD);
                    end else if (tick && (seconds_left_r <= 6'd1)) begin
                        state     <= S_LOSE;
                        div_cnt   <= DIV_LOAD;
                        fail_r    <= 1'b1;
                        game_en_r <= '0;
                        bits_r    <= LOSE_BITS;
                    end
                end

                S_WIN: begin
                    bits_r <= cur_bits;
                    if (tick) begin
                        div_cnt <= DIV_LOAD;
                        if (hold_cnt <= 6'd1) begin
                            if (game_idx_r == 3'(NUM_GAMES - 1)) begin
                                state     <= S_DONE;
                                done_r    <= 1'b1;
                                game_en_r <= '0;
                                bits_r    <= {BLANK, BLANK, 1'b0, el_tens, 1'b0, el_ones};
                            end else begin
                                state          <= S_LOAD;
                                game_idx_r     <= game_idx_r + 3'd1;
                                game_en_r      <= NUM_GAMES'(1) << (game_idx_r + 3'd1);
                                game_counter_r <= '0;
                                seconds_left_r <= 6'(TIME_LIMIT);
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 6'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.game_en      = game_en_r;
    assign bus.game_idx     = game_idx_r;
    assign bus.game_counter = game_counter_r;
    assign bus.bits         = bits_r;
    assign bus.seconds_left = seconds_left_r;
    assign bus.done         = done_r;
    assign bus.fail         = fail_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with NUM_GAMES=3, TICK_DIV=4,
// TIME_LIMIT=3, WIN_HOLD=1. Inputs change and outputs are sampled 1 ns
// after each rising edge.
module tb_game_sequencer;

    localparam logic [19:0] DASH4     = 20'b10000100001000010000;
    localparam logic [19:0] LOSE_BITS = {5'b11111, 5'b10000, 5'b10000, 5'b11111};
    localparam logic [19:0] DONE_BITS = {5'b11111, 5'b11111, 5'b00000, 5'b00011};
    localparam logic [19:0] GB0  = {5'd1, 5'd2, 5'd3, 5'd4};
    localparam logic [19:0] GB1  = {5'd5, 5'd6, 5'd7, 5'd8};
    localparam logic [19:0] GB2  = {5'd9, 5'd0, 5'd1, 5'd2};
    localparam logic [19:0] GB2B = {5'b11111, 5'd7, 5'b10000, 5'd3};

    logic clk = 1'b0;
    logic reset_n;
    int   tests  = 0;
    int   failed = 0;

    game_sequencer_if #(.NUM_GAMES(3)) bus ();

    game_sequencer #(
        .NUM_GAMES (3),
        .TICK_DIV  (4),
        .TIME_LIMIT(3),
        .WIN_HOLD  (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.score_pulse = 1'b0;
        bus.victory     = 3'b000;
        bus.game_bits   = {GB2, GB1, GB0};
        cyc(2);
        reset_n = 1'b1;

        // Reset and idle
        cyc(10);
        chk("idle_bits", bus.bits, DASH4);
        chk("idle_en", bus.game_en, 3'b000);
        chk("idle_done", bus.done, 1'b0);
        chk("idle_fail", bus.fail, 1'b0);
        chk("idle_secs", bus.seconds_left, 6'd0);
        chk("idle_idx", bus.game_idx, 3'd0);
        chk("idle_cnt", bus.game_counter, 3'd0);

        // Game 0: score three times, win after the first tick
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("load0_en", bus.game_en, 3'b001);
        chk("load0_secs", bus.seconds_left, 6'd3);
        cyc(1);
        chk("play0_bits", bus.bits, GB0);
        bus.score_pulse = 1'b1;
        cyc(3);
        bus.score_pulse = 1'b0;
        chk("score3", bus.game_counter, 3'd3);
        chk("pretick_secs", bus.seconds_left, 6'd3);
        cyc(1);
        chk("tick1_secs", bus.seconds_left, 6'd2);
        bus.victory = 3'b001;
        cyc(1);
        bus.victory = 3'b000;
        chk("win0_en", bus.game_en, 3'b001);
        bus.score_pulse = 1'b1;
        cyc(1);
        bus.score_pulse = 1'b0;
        chk("win_frozen_cnt", bus.game_counter, 3'd3);
        cyc(2);
        chk("win_hold_en", bus.game_en, 3'b001);
        chk("win_hold_idx", bus.game_idx, 3'd0);
        cyc(1);
        chk("load1_idx", bus.game_idx, 3'd1);
        chk("load1_en", bus.game_en, 3'b010);
        chk("load1_cnt", bus.game_counter, 3'd0);
        chk("load1_secs", bus.seconds_left, 6'd3);

        // Game 1 times out; start during LOAD is ignored
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("ign_start_idx", bus.game_idx, 3'd1);
        chk("play1_bits", bus.bits, GB1);
        cyc(11);
        chk("pre_lose_secs", bus.seconds_left, 6'd1);
        chk("pre_lose_fail", bus.fail, 1'b0);
        cyc(1);
        chk("lose_fail", bus.fail, 1'b1);
        chk("lose_en", bus.game_en, 3'b000);
        chk("lose_bits", bus.bits, LOSE_BITS);
        chk("lose_secs", bus.seconds_left, 6'd0);
        cyc(3);
        chk("lose_sticky", bus.fail, 1'b1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("restart_fail", bus.fail, 1'b0);
        chk("restart_idx", bus.game_idx, 3'd0);
        chk("restart_en", bus.game_en, 3'b001);

        // Win all three games, each after one tick
        cyc(5);
        bus.victory = 3'b001;
        cyc(1);
        bus.victory = 3'b000;
        cyc(4);
        chk("all_idx1", bus.game_idx, 3'd1);
        cyc(5);
        bus.victory = 3'b010;
        cyc(1);
        bus.victory = 3'b000;
        cyc(4);
        chk("all_idx2", bus.game_idx, 3'd2);
        chk("all_en2", bus.game_en, 3'b100);
        cyc(1);
        chk("play2_bits", bus.bits, GB2);
        bus.game_bits[59:40] = GB2B;
        cyc(1);
        chk("play2_bits_upd", bus.bits, GB2B);
        cyc(3);
        bus.victory = 3'b100;
        cyc(1);
        bus.victory = 3'b000;
        cyc(4);
        chk("done_flag", bus.done, 1'b1);
        chk("done_en", bus.game_en, 3'b000);
        chk("done_bits", bus.bits, DONE_BITS);
        chk("done_fail", bus.fail, 1'b0);
        cyc(2);
        chk("done_sticky", bus.done, 1'b1);

        // Restart; foreign victory ignored; victory beats expiring tick
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("rs_done_clr", bus.done, 1'b0);
        chk("rs_idx", bus.game_idx, 3'd0);
        cyc(1);
        bus.victory = 3'b100;
        cyc(4);
        chk("foreign_en_a", bus.game_en, 3'b001);
        chk("foreign_secs_a", bus.seconds_left, 6'd2);
        cyc(4);
        chk("foreign_en_b", bus.game_en, 3'b001);
        chk("foreign_secs_b", bus.seconds_left, 6'd1);
        cyc(3);
        bus.victory = 3'b001;
        cyc(1);
        bus.victory = 3'b000;
        chk("race_fail", bus.fail, 1'b0);
        chk("race_en", bus.game_en, 3'b001);
        cyc(4);
        chk("race_next_idx", bus.game_idx, 3'd1);
        chk("race_next_fail", bus.fail, 1'b0);

        // Score saturation, then reset during PLAY
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
        bus.score_pulse = 1'b1;
        cyc(9);
        bus.score_pulse = 1'b0;
        chk("sat_cnt", bus.game_counter, 3'd7);
        chk("sat_secs", bus.seconds_left, 6'd1);
        chk("sat_en", bus.game_en, 3'b001);
        reset_n = 1'b0;
        cyc(1);
        chk("rst_bits", bus.bits, DASH4);
        chk("rst_en", bus.game_en, 3'b000);
        chk("rst_cnt", bus.game_counter, 3'd0);
        chk("rst_secs", bus.seconds_left, 6'd0);
        chk("rst_idx", bus.game_idx, 3'd0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_fail", bus.fail, 1'b0);
        reset_n = 1'b1;
        cyc(2);
        chk("post_rst_bits", bus.bits, DASH4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level controller that steps the player through NUM_GAMES mini-games in fixed order, sharing the single 20-bit four-digit seven-segment display bus among them. It enables one game at a time and routes that game's digit codes to the display. It supplies the game's progress counter and enforces a per-game countdown. It advances on the game's victory flag and reports overall completion or failure.

## Interface
- NUM_GAMES, 3: number of games sequenced (1..7)
- TICK_DIV, 50_000_000: clk cycles per one-second tick (>= 2)
- TIME_LIMIT, 30: seconds allowed per game (1..63)
- WIN_HOLD, 2: seconds the winning game's display is held before advancing (1..63)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle pulse; begins or restarts the sequence
- score_pulse  in  1  single-cycle player success event for the active game
- game_bits  in  20*NUM_GAMES  packed display codes; game i occupies [20i+19:20i]
- victory  in  NUM_GAMES  per-game victory flags
- game_en  out  NUM_GAMES  one-hot enable of the active game; 0 when none is active
- game_idx  out  3  index of the current game
- game_counter  out  3  progress count fed to the active game
- bits  out  20  display bus: digit 1 at [19:15] through digit 4 at [4:0]
- seconds_left  out  6  remaining seconds for the current game
- done  out  1  all games won
- fail  out  1  current game timed out

## Operation
- Digit codes (5 bit): 0..9 are binary values; 5'b10000 is dash; 5'b11111 is blank.
- FSM states: IDLE, LOAD, PLAY, WIN, LOSE, DONE. Reset enters IDLE.
- IDLE:
  - bits = four dashes (20'b10000100001000010000); all enables, done and fail = 0.
  - start -> LOAD with game_idx=0; elapsed digits cleared.
- LOAD (1 cycle):
  - game_counter=0, seconds_left=TIME_LIMIT, tick divider cleared.
  - game_en[game_idx]=1.
  - -> PLAY.
- PLAY:
  - bits = game_bits slice [game_idx].
  - score_pulse increments game_counter, saturating at 7.
  - victory[game_idx] -> WIN. victory bits of other games are ignored.
  - If a tick brings seconds_left to 0 -> LOSE.
  - If victory and the expiring tick occur in the same cycle, victory wins.
- WIN:
  - game_en and bits are held as in PLAY; game_counter is frozen.
  - After WIN_HOLD ticks: if game_idx == NUM_GAMES-1 -> DONE; else game_idx+1 -> LOAD.
- LOSE:
  - fail=1, game_en=0, bits = {blank, dash, dash, blank}.
  - Sticky until start.
- DONE:
  - done=1, game_en=0, bits = {blank, blank, tens, ones} of total elapsed seconds.
  - Sticky until start.
- start in LOSE or DONE -> LOAD with game_idx=0; elapsed digits cleared; done and fail cleared.
- start is ignored in LOAD, PLAY and WIN.
- Elapsed counter: two BCD digits.
  - Increments once per tick in PLAY only.
  - Ones wrap 9->0 with a carry into tens.
  - Saturates at 99.
- Tick divider: counts 0..TICK_DIV-1 and produces a one-cycle tick at TICK_DIV-1.
  - Runs only in PLAY and WIN.
  - Cleared on every state entry.

## Timing
- All outputs are registered. Input-to-output latency is 1 cycle: game_bits and victory sampled at edge n affect bits and state at edge n+1.
- Reset values:
  - state IDLE; game_idx=0; game_counter=0; seconds_left=0.
  - game_en=0; done=0; fail=0; bits = four dashes; elapsed = 00.
- Reset asserted mid-operation: all of the above take effect on the next clk edge regardless of state.
- A game in PLAY with no events lasts exactly TIME_LIMIT*TICK_DIV cycles from LOAD exit to LOSE entry.
- WIN lasts WIN_HOLD*TICK_DIV cycles.
- seconds_left decrements on the tick edge and never underflows.

## Test plan
Parameters for all tests: NUM_GAMES=3, TICK_DIV=4, TIME_LIMIT=3, WIN_HOLD=1.
- Reset, then idle 10 cycles -> bits=20'b10000100001000010000, game_en=0, done=0, fail=0, seconds_left=0.
- start; 3 score_pulses; victory[0] at cycle 8 -> game_counter=3, enters WIN, game_en=3'b001 held 4 cycles, then LOAD with game_idx=1, game_en=3'b010, game_counter=0, seconds_left=3.
- start; no victory -> after 12 PLAY cycles fail=1, game_en=0, bits = {11111,10000,10000,11111}; a further start returns to game 0 with fail=0.
- Win all 3 games, each after 1 tick -> done=1, bits = {11111,11111,00000,00011}.
- victory[0] on the same cycle as the expiring tick -> WIN, fail stays 0. Also: victory[2] asserted while game 0 is active -> no effect.
- 9 score_pulses in game 0 -> game_counter saturates at 7. Assert reset_n=0 during PLAY -> next edge: IDLE, all outputs at reset values.
